// File: rtl/fp_seq_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// fp_seq_pkg
// Shared definitions for the sequential floating-point subtractor:
//   - fp_state_e      : controller state encoding
//   - FP_EXP_WIDTH_DEF: default exponent field width (single precision)
//   - FP_MANT_WIDTH_DEF: default stored fraction width (single precision)
// ---------------------------------------------------------------------------
package fp_seq_pkg;

   localparam int FP_EXP_WIDTH_DEF  = 8;
   localparam int FP_MANT_WIDTH_DEF = 23;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ALIGN = 3'd1,
      S_OP    = 3'd2,
      S_NORM  = 3'd3,
      S_DONE  = 3'd4
   } fp_state_e;

endpackage : fp_seq_pkg

// File: rtl/fp_seq_subtractor_alu_c.sv
// ---------------------------------------------------------------------------
// alu_c
// Unsigned add/subtract of two WIDTH-bit operands with carry/borrow out.
//   alu_A_in  : first operand
//   alu_B_in  : second operand
//   alu_sub_in: 1 = A - B, 0 = A + B
//   alu_Y_out : WIDTH-bit result
//   alu_C_out : carry-out on add, borrow-out on subtract
// ---------------------------------------------------------------------------
module alu_c #(
   parameter int WIDTH = 24
) (
   input  logic [WIDTH-1:0] alu_A_in,
   input  logic [WIDTH-1:0] alu_B_in,
   input  logic             alu_sub_in,
   output logic [WIDTH-1:0] alu_Y_out,
   output logic             alu_C_out
);

   logic [WIDTH:0] res_s;

   // Extended-width add or subtract so the top bit captures carry/borrow
   always_comb begin
      res_s = {(WIDTH+1){1'b0}};
      if (alu_sub_in) begin
         res_s = {1'b0, alu_A_in} - {1'b0, alu_B_in};
      end else begin
         res_s = {1'b0, alu_A_in} + {1'b0, alu_B_in};
      end
   end

   assign alu_Y_out = res_s[WIDTH-1:0];
   assign alu_C_out = res_s[WIDTH];

endmodule : alu_c

// File: rtl/fp_seq_subtractor.sv
// ---------------------------------------------------------------------------
// fp_seq_subtractor
// Multi-cycle floating-point subtractor computing a - b. Alignment and
// normalization are done one bit per cycle.
//   clk_in        : clock, all state on rising edge
//   rst_n_in      : synchronous active-low reset
//   start_in      : request, accepted only while idle
//   a_in, b_in    : operands {sign, exponent, fraction}
//   ready_out     : high while idle
//   done_out      : one-cycle pulse when fps_out/flags are updated
//   fps_out       : result, held until the next done_out
//   overflow_out  : result saturated to signed infinity
//   underflow_out : result flushed to zero because exponent fell below 1
// ---------------------------------------------------------------------------
module fp_seq_subtractor
   import fp_seq_pkg::*;
#(
   parameter int EXP_WIDTH      = FP_EXP_WIDTH_DEF,
   parameter int MANTISSA_WIDTH = FP_MANT_WIDTH_DEF
) (
   input  logic                              clk_in,
   input  logic                              rst_n_in,
   input  logic                              start_in,
   input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] a_in,
   input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] b_in,
   output logic                              ready_out,
   output logic                              done_out,
   output logic [EXP_WIDTH+MANTISSA_WIDTH:0] fps_out,
   output logic                              overflow_out,
   output logic                              underflow_out
);

   localparam int W     = EXP_WIDTH + MANTISSA_WIDTH + 1;
   localparam int M     = MANTISSA_WIDTH;
   localparam int CNT_W = $clog2(MANTISSA_WIDTH + 3);

   localparam logic [EXP_WIDTH-1:0] EXP_ONE     = EXP_WIDTH'(1);
   localparam logic [EXP_WIDTH-1:0] EXP_ONES    = {EXP_WIDTH{1'b1}};
   localparam logic [EXP_WIDTH-1:0] MAX_SHIFT_E = EXP_WIDTH'(MANTISSA_WIDTH + 2);
   localparam logic [CNT_W-1:0]     MAX_SHIFT_C = CNT_W'(MANTISSA_WIDTH + 2);
   localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]     CNT_ZERO    = {CNT_W{1'b0}};

   fp_state_e            state_r, state_next_s;
   logic                 sign_r, sub_r;
   logic [EXP_WIDTH-1:0] exp_r;
   logic [M:0]           big_mant_r, small_mant_r;
   logic [M+1:0]         sum_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [W-1:0]         fps_r;
   logic                 ovf_r, unf_r, done_r, ready_r;

   // Operand decode used on the accepting edge
   logic [EXP_WIDTH-1:0] a_exp_s, b_exp_s, exp_diff_s;
   logic [M:0]           a_mant_s, b_mant_s;
   logic                 a_ge_b_s, sub_s;
   logic [CNT_W-1:0]     shift_cnt_s;

   assign a_exp_s    = a_in[W-2:M];
   assign b_exp_s    = b_in[W-2:M];
   assign a_mant_s   = {1'b1, a_in[M-1:0]};
   assign b_mant_s   = {1'b1, b_in[M-1:0]};
   // Exponent sits above fraction, so one compare orders magnitudes
   assign a_ge_b_s   = (a_in[W-2:0] >= b_in[W-2:0]);
   // Subtracting b is adding -b: subtract when signs agree
   assign sub_s      = ~(a_in[W-1] ^ b_in[W-1]);
   assign exp_diff_s = a_ge_b_s ? (a_exp_s - b_exp_s) : (b_exp_s - a_exp_s);
   // Beyond M+2 shifts the lesser mantissa is already all zeros
   assign shift_cnt_s = (exp_diff_s > MAX_SHIFT_E) ? MAX_SHIFT_C : CNT_W'(exp_diff_s);

   // Mantissa add/subtract of aligned operands
   logic [M:0] alu_y_s;
   logic       alu_c_s;

   alu_c #(.WIDTH(M + 1)) u_alu (
      .alu_A_in  (big_mant_r),
      .alu_B_in  (small_mant_r),
      .alu_sub_in(sub_r),
      .alu_Y_out (alu_y_s),
      .alu_C_out (alu_c_s)
   );

   // Normalization decisions
   logic                 sum_zero_s, carry_s, hidden_s, exp_ovf_s, exp_unf_s;
   logic [EXP_WIDTH-1:0] exp_inc_s, exp_dec_s;

   assign sum_zero_s = (sum_r == {(M+2){1'b0}});
   assign carry_s    = sum_r[M+1];
   assign hidden_s   = sum_r[M];
   assign exp_inc_s  = exp_r + EXP_ONE;
   assign exp_dec_s  = exp_r - EXP_ONE;
   assign exp_ovf_s  = (exp_inc_s == EXP_ONES);
   assign exp_unf_s  = (exp_r <= EXP_ONE);

   // Controller state register
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Controller next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start_in) state_next_s = S_ALIGN;
            else          state_next_s = S_IDLE;
         end
         S_ALIGN: begin
            if (cnt_r != CNT_ZERO) state_next_s = S_ALIGN;
            else                   state_next_s = S_OP;
         end
         S_OP: state_next_s = S_NORM;
         S_NORM: begin
            if (sum_zero_s) begin
               state_next_s = S_DONE;
            end else if (carry_s) begin
               if (exp_ovf_s) state_next_s = S_DONE;
               else           state_next_s = S_NORM;
            end else if (!hidden_s) begin
               if (exp_unf_s) state_next_s = S_DONE;
               else           state_next_s = S_NORM;
            end else begin
               state_next_s = S_DONE;
            end
         end
         S_DONE:  state_next_s = S_IDLE;
         default: state_next_s = S_IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         sign_r       <= 1'b0;
         sub_r        <= 1'b0;
         exp_r        <= {EXP_WIDTH{1'b0}};
         big_mant_r   <= {(M+1){1'b0}};
         small_mant_r <= {(M+1){1'b0}};
         sum_r        <= {(M+2){1'b0}};
         cnt_r        <= CNT_ZERO;
         fps_r        <= {W{1'b0}};
         ovf_r        <= 1'b0;
         unf_r        <= 1'b0;
         done_r       <= 1'b0;
         ready_r      <= 1'b1;
      end else begin
         done_r  <= 1'b0;
         ready_r <= (state_next_s == S_IDLE);
         case (state_r)
            S_IDLE: begin
               if (start_in) begin
                  sub_r <= sub_s;
                  cnt_r <= shift_cnt_s;
                  if (a_ge_b_s) begin
                     sign_r       <= a_in[W-1];
                     exp_r        <= a_exp_s;
                     big_mant_r   <= a_mant_s;
                     small_mant_r <= b_mant_s;
                  end else begin
                     sign_r       <= ~b_in[W-1];
                     exp_r        <= b_exp_s;
                     big_mant_r   <= b_mant_s;
                     small_mant_r <= a_mant_s;
                  end
               end
            end
            S_ALIGN: begin
               if (cnt_r != CNT_ZERO) begin
                  small_mant_r <= {1'b0, small_mant_r[M:1]};
                  cnt_r        <= cnt_r - CNT_ONE;
               end
            end
            S_OP: sum_r <= {alu_c_s, alu_y_s};
            S_NORM: begin
               if (sum_zero_s) begin
                  fps_r  <= {W{1'b0}};
                  ovf_r  <= 1'b0;
                  unf_r  <= 1'b0;
                  done_r <= 1'b1;
               end else if (carry_s) begin
                  if (exp_ovf_s) begin
                     fps_r  <= {sign_r, EXP_ONES, {M{1'b0}}};
                     ovf_r  <= 1'b1;
                     unf_r  <= 1'b0;
                     done_r <= 1'b1;
                  end else begin
                     sum_r <= {1'b0, sum_r[M+1:1]};
                     exp_r <= exp_inc_s;
                  end
               end else if (!hidden_s) begin
                  if (exp_unf_s) begin
                     fps_r  <= {W{1'b0}};
                     ovf_r  <= 1'b0;
                     unf_r  <= 1'b1;
                     done_r <= 1'b1;
                  end else begin
                     sum_r <= {sum_r[M:0], 1'b0};
                     exp_r <= exp_dec_s;
                  end
               end else begin
                  fps_r  <= {sign_r, exp_r, sum_r[M-1:0]};
                  ovf_r  <= 1'b0;
                  unf_r  <= 1'b0;
                  done_r <= 1'b1;
               end
            end
            S_DONE:  ;
            default: ;
         endcase
      end
   end

   assign ready_out     = ready_r;
   assign done_out      = done_r;
   assign fps_out       = fps_r;
   assign overflow_out  = ovf_r;
   assign underflow_out = unf_r;

endmodule : fp_seq_subtractor

// File: tb/tb_fp_seq_subtractor.sv
// ---------------------------------------------------------------------------
// tb_fp_seq_subtractor
// Directed-vector bench for fp_seq_subtractor at single precision.
// ---------------------------------------------------------------------------
module tb_fp_seq_subtractor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] a, b;
   logic        ready, done, ovf, unf;
   logic [31:0] fps;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fp_seq_subtractor #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
      .clk_in       (clk),
      .rst_n_in     (rst_n),
      .start_in     (start),
      .a_in         (a),
      .b_in         (b),
      .ready_out    (ready),
      .done_out     (done),
      .fps_out      (fps),
      .overflow_out (ovf),
      .underflow_out(unf)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // mode 0: plain; 1: pulse start while aligning; 2: hold start on DONE->IDLE edge
   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_fps, input logic exp_ovf, input logic exp_unf,
                         input int exp_lat, input int mode);
      int lat;
      bit seen;
      @(negedge clk);
      check_eq({tag, "_ready_idle"}, {31'd0, ready}, 32'd1);
      a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq({tag, "_ready_busy"}, {31'd0, ready}, 32'd0);
      lat = 0; seen = 1'b0;
      while (!seen && lat < 100) begin
         if (mode == 1 && lat == 3) begin
            start = 1'b1; a = 32'h40A00000; b = 32'h3F800000;
         end
         if (mode == 1 && lat == 4) start = 1'b0;
         @(posedge clk); #1;
         lat++;
         if (done) seen = 1'b1;
      end
      check_eq({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
      if (exp_lat != 0) check_eq({tag, "_latency"}, lat, exp_lat);
      check_eq({tag, "_fps"}, fps, exp_fps);
      check_eq({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
      check_eq({tag, "_unf"}, {31'd0, unf}, {31'd0, exp_unf});
      check_eq({tag, "_ready_in_done"}, {31'd0, ready}, 32'd0);
      if (mode == 2) begin
         start = 1'b1; a = 32'h40A00000; b = 32'h3F800000;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check_eq({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
      check_eq({tag, "_fps_held"}, fps, exp_fps);
      if (mode == 2) begin
         @(posedge clk); #1;
         check_eq({tag, "_no_late_accept"}, {31'd0, ready}, 32'd1);
      end
   endtask

   // Start an add with a carry, reset while normalizing, expect a clean abort
   task automatic reset_mid_op();
      int lat;
      int done_cnt;
      @(negedge clk);
      a = 32'h3F800000; b = 32'hBF800000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; done_cnt = 0;
      while (lat < 2) begin
         @(posedge clk); #1;
         lat++;
         if (done) done_cnt++;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_eq("rst_mid_fps", fps, 32'h0);
      check_eq("rst_mid_ovf", {31'd0, ovf}, 32'd0);
      check_eq("rst_mid_unf", {31'd0, unf}, 32'd0);
      check_eq("rst_mid_done", {31'd0, done}, 32'd0);
      check_eq("rst_mid_ready", {31'd0, ready}, 32'd1);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
      end
      check_eq("rst_mid_no_done", done_cnt, 0);
      check_eq("rst_mid_idle", {31'd0, ready}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = 32'h0; b = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_fps", fps, 32'h0);
      check_eq("reset_done", {31'd0, done}, 32'd0);
      check_eq("reset_ovf", {31'd0, ovf}, 32'd0);
      check_eq("reset_unf", {31'd0, unf}, 32'd0);
      check_eq("reset_ready", {31'd0, ready}, 32'd1);
      rst_n = 1'b1;

      //      tag          a             b             result        ovf   unf   lat mode
      run_op("3m1",      32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4,  0);
      run_op("1m1",      32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 3,  0);
      run_op("1mneg1",   32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0, 4,  0);
      run_op("1m3",      32'h3F800000, 32'h40400000, 32'hC0000000, 1'b0, 1'b0, 4,  0);
      run_op("1p5m1p25", 32'h3FC00000, 32'h3FA00000, 32'h3E800000, 1'b0, 1'b0, 5,  0);
      run_op("neg3mneg2",32'hC0400000, 32'hC0000000, 32'hBF800000, 1'b0, 1'b0, 4,  0);
      run_op("2mneg0p5", 32'h40000000, 32'hBF000000, 32'h40200000, 1'b0, 1'b0, 5,  0);
      run_op("underflow",32'h00C00000, 32'h00A00000, 32'h00000000, 1'b0, 1'b1, 3,  0);
      run_op("overflow", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 1'b0, 0,  0);
      reset_mid_op();
      run_op("clamp_d25",32'h3F800000, 32'h30800000, 32'h3F800000, 1'b0, 1'b0, 28, 1);
      run_op("restart",  32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4,  2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_fp_seq_subtractor

// File: doc/fp_seq_subtractor.md
FP_SEQ_SUBTRACTOR -- requirements
Module: fp_seq_subtractor

Interface
REQ-001 Parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 Parameter MANTISSA_WIDTH, default 23, stored fraction width; W = EXP_WIDTH+MANTISSA_WIDTH+1.
REQ-003 clk_in  input  1  single clock, all state on rising edge.
REQ-004 rst_n_in  input  1  reset, synchronous, active-low.
REQ-005 start_in  input  1  request; accepted only in IDLE.
REQ-006 a_in  input  W  minuend {sign, exp, fraction}, sampled on accepting edge.
REQ-007 b_in  input  W  subtrahend, same format, sampled on accepting edge.
REQ-008 ready_out  output  1  high exactly while in IDLE.
REQ-009 done_out  output  1  one-cycle pulse, result valid.
REQ-010 fps_out  output  W  result a-b, held until next done_out.
REQ-011 overflow_out, underflow_out  output  1 each  flags, valid and held with fps_out.

Function
REQ-012 All operands SHALL be treated as normal numbers with hidden bit 1; no NaN/Inf/denormal handling.
REQ-013 Effective b sign SHALL be ~b_sign; effective op = add if a_sign == ~b_sign, else subtract.
REQ-014 Operand with larger magnitude (exponent, then fraction on tie) SHALL be "greater"; result sign = its effective sign; exact tie in subtract gives +0.
REQ-015 States SHALL be IDLE, ALIGN, OP, NORM, DONE; start_in outside IDLE is ignored.
REQ-016 IDLE: on start_in=1, capture operands, load shift count d = min(|ea-eb|, MANTISSA_WIDTH+2), go ALIGN.
REQ-017 ALIGN: per cycle, if count != 0 shift lesser (MANTISSA_WIDTH+1)-bit mantissa right 1 and decrement, else go OP; shifted-out bits discarded (truncation).
REQ-018 OP: one cycle, greater +/- lesser with carry-out into a (MANTISSA_WIDTH+2)-bit register, go NORM.
REQ-019 NORM: per cycle, in priority order: sum zero -> result +0, go DONE; carry set -> shift right 1, exp+1; hidden bit clear -> shift left 1, exp-1; else go DONE.
REQ-020 Overflow: exponent reaching all-ones SHALL give fps_out = {sign, all-ones, 0}, overflow_out=1, go DONE.
REQ-021 Underflow: exponent decrement below 1 SHALL give fps_out = 0, underflow_out=1, go DONE.
REQ-022 DONE: one cycle, done_out=1, fps_out/flags updated on entry, then IDLE.
REQ-023 Latency from accepting edge to done_out SHALL be d + k + 3 edges, k = NORM shifts performed.
REQ-024 Start on the same edge DONE returns to IDLE SHALL NOT be accepted; ready_out rises the following cycle.

Reset
REQ-025 rst_n_in=0 at any edge, including mid-operation, SHALL force IDLE and clear fps_out, done_out, overflow_out, underflow_out to 0; ready_out=1 the following cycle.
REQ-026 An in-flight operation aborted by reset SHALL produce no done_out.

Structure
REQ-027 Package fp_seq_pkg SHALL hold the state enum and default width constants.
REQ-028 OP-state mantissa add/subtract SHALL instantiate existing alu_c at width MANTISSA_WIDTH+1, carry from alu_C_out.
REQ-029 Alignment and normalization SHALL be single-bit shift registers, no barrel shifter.

Verification
REQ-030 a=0x40400000, b=0x3F800000 -> fps_out 0x40000000, flags 0, done_out 4 edges after accept.
REQ-031 a=0x3F800000, b=0x3F800000 -> fps_out 0x00000000, underflow_out 0.
REQ-032 a=0x3F800000, b=0xBF800000 -> fps_out 0x40000000 (carry path), done_out 4 edges after accept.
REQ-033 a=0x3F800000, b=0x40400000 -> fps_out 0xC0000000 (swap, negative sign).
REQ-034 a=0x7F7FFFFF, b=0xFF7FFFFF -> fps_out 0x7F800000, overflow_out 1; a=0x3F800000, b=0x30800000 -> 0x3F800000 with d clamped to 25.
REQ-035 start_in pulsed during ALIGN ignored; rst_n_in low during NORM -> IDLE, outputs 0, no done_out.
